coin_payout_ctrl: RTL and testbench

Payout-side controller for the vending FSM. It consumes the FSM's single-cycle `T` (vend) and `C0`/`C1` (change) outputs and drives the physical actuators. Change requests are queued and paid out one coin at a time through a hopper enable/sense handshake, with per-coin-type inventory counters. `T` fires a fixed-width vend solenoid pulse. The block sits between `FSM` and the machine I/O pads.

---
 rtl/coin_payout_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_coin_payout_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_payout_ctrl.sv
// coin_payout_ctrl: payout-side controller between the vending FSM and the I/O pads.
// Change requests are queued one bit per entry (coin type). They are paid out one coin
// at a time through a hopper enable/sense handshake, with per-type inventory tracking.
// A vend request drives a fixed-width solenoid pulse that is independent of the payout path.
module coin_payout_ctrl #(
    parameter int QDEPTH      = 4,
    parameter int INV_W       = 8,
    parameter int TIMEOUT     = 16,
    parameter int VEND_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             T,
    input  logic             C0,
    input  logic             C1,
    input  logic             LOAD,
    input  logic [INV_W-1:0] LOAD_CNT0,
    input  logic [INV_W-1:0] LOAD_CNT1,
    input  logic             SENSE0,
    input  logic             SENSE1,
    input  logic             CLR_FAULT,
    output logic             HOP0_EN,
    output logic             HOP1_EN,
    output logic             VEND,
    output logic             BUSY,
    output logic             OVF,
    output logic             EMPTY0,
    output logic             EMPTY1,
    output logic             FAULT,
    output logic [INV_W-1:0] INV0,
    output logic [INV_W-1:0] INV1
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int VW = $clog2(VEND_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPENSE,
        ST_GAP,
        ST_FAULT
    } state_t;

    state_t          state_q, state_n;
    logic            type_q, type_n;
    logic [TW-1:0]   timer_q, timer_n;

    logic [QDEPTH-1:0] q_mem;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     q_count, q_count_n, q_free;
    logic              push0, push1, pop, drop;
    logic              head_type;

    logic              dec0, dec1, set_empty0, set_empty1;
    logic [VW-1:0]     vend_cnt;

    assign head_type = q_mem[rd_ptr];

    // Decide which of the incoming requests fit; C0 claims a free slot before C1.
    always_comb begin
        q_free    = CW'(QDEPTH) - q_count;
        push0     = C0 && (q_free != '0);
        push1     = C1 && (push0 ? (q_free >= CW'(2)) : (q_free != '0));
        drop      = (C0 && !push0) || (C1 && !push1);
        q_count_n = q_count + CW'(push0) + CW'(push1) - CW'(pop);
    end

    // Circular request buffer; a pop frees its slot only after the edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_mem   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push0) begin
                q_mem[wr_ptr] <= 1'b0;
            end
            if (push1) begin
                q_mem[push0 ? (wr_ptr + PW'(1)) : wr_ptr] <= 1'b1;
            end
            wr_ptr  <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr  <= rd_ptr + PW'(pop);
            q_count <= q_count_n;
        end
    end

    // Payout sequencing: pop in IDLE, wait for the coin-exit sense, then one quiet cycle.
    always_comb begin
        state_n    = state_q;
        type_n     = type_q;
        timer_n    = timer_q;
        pop        = 1'b0;
        dec0       = 1'b0;
        dec1       = 1'b0;
        set_empty0 = 1'b0;
        set_empty1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (q_count != '0) begin
                    pop = 1'b1;
                    if (head_type) begin
                        if (INV1 != '0) begin
                            type_n  = 1'b1;
                            timer_n = TW'(TIMEOUT);
                            state_n = ST_DISPENSE;
                        end else begin
                            set_empty1 = 1'b1;
                        end
                    end else begin
                        if (INV0 != '0) begin
                            type_n  = 1'b0;
                            timer_n = TW'(TIMEOUT);
                            state_n = ST_DISPENSE;
                        end else begin
                            set_empty0 = 1'b1;
                        end
                    end
                end
            end
            ST_DISPENSE: begin
                if (!type_q && SENSE0) begin
                    dec0    = 1'b1;
                    state_n = ST_GAP;
                end else if (type_q && SENSE1) begin
                    dec1    = 1'b1;
                    state_n = ST_GAP;
                end else if (timer_q <= TW'(1)) begin
                    timer_n = '0;
                    state_n = ST_FAULT;
                end else begin
                    timer_n = timer_q - TW'(1);
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            ST_FAULT: begin
                if (CLR_FAULT) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status outputs derived from the next state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            type_q  <= 1'b0;
            timer_q <= '0;
            HOP0_EN <= 1'b0;
            HOP1_EN <= 1'b0;
            BUSY    <= 1'b0;
            FAULT   <= 1'b0;
            OVF     <= 1'b0;
            EMPTY0  <= 1'b0;
            EMPTY1  <= 1'b0;
        end else begin
            state_q <= state_n;
            type_q  <= type_n;
            timer_q <= timer_n;
            HOP0_EN <= (state_n == ST_DISPENSE) && !type_n;
            HOP1_EN <= (state_n == ST_DISPENSE) && type_n;
            BUSY    <= (q_count_n != '0) || (state_n != ST_IDLE);
            FAULT   <= (state_n == ST_FAULT);
            OVF     <= OVF | drop;
            EMPTY0  <= EMPTY0 | set_empty0;
            EMPTY1  <= EMPTY1 | set_empty1;
        end
    end

    // Inventory counters; a load overrides a coincident decrement, and zero never wraps.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            INV0 <= '0;
            INV1 <= '0;
        end else if (LOAD) begin
            INV0 <= LOAD_CNT0;
            INV1 <= LOAD_CNT1;
        end else begin
            if (dec0 && (INV0 != '0)) begin
                INV0 <= INV0 - INV_W'(1);
            end
            if (dec1 && (INV1 != '0)) begin
                INV1 <= INV1 - INV_W'(1);
            end
        end
    end

    // Vend pulse stretcher; a new request restarts the full width.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VEND     <= 1'b0;
            vend_cnt <= '0;
        end else if (T) begin
            VEND     <= 1'b1;
            vend_cnt <= VW'(VEND_CYCLES - 1);
        end else if (vend_cnt != '0) begin
            vend_cnt <= vend_cnt - VW'(1);
        end else begin
            VEND <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// tb_coin_payout_ctrl: directed bench for the coin payout controller.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_coin_payout_ctrl;

    logic       CLK;
    logic       RESET;
    logic       T, C0, C1, LOAD, SENSE0, SENSE1, CLR_FAULT;
    logic [7:0] LOAD_CNT0, LOAD_CNT1;
    logic       HOP0_EN, HOP1_EN, VEND, BUSY, OVF, EMPTY0, EMPTY1, FAULT;
    logic [7:0] INV0, INV1;

    int   checks = 0;
    int   errors = 0;
    int   hop1_rises = 0;
    logic hop1_prev = 1'b0;
    logic overlap_seen = 1'b0;

    coin_payout_ctrl #(
        .QDEPTH(4), .INV_W(8), .TIMEOUT(16), .VEND_CYCLES(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .T(T), .C0(C0), .C1(C1), .LOAD(LOAD),
        .LOAD_CNT0(LOAD_CNT0), .LOAD_CNT1(LOAD_CNT1),
        .SENSE0(SENSE0), .SENSE1(SENSE1), .CLR_FAULT(CLR_FAULT),
        .HOP0_EN(HOP0_EN), .HOP1_EN(HOP1_EN), .VEND(VEND), .BUSY(BUSY),
        .OVF(OVF), .EMPTY0(EMPTY0), .EMPTY1(EMPTY1), .FAULT(FAULT),
        .INV0(INV0), .INV1(INV1)
    );

    // Free-running 10ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count hopper-1 enable rises and watch for both enables high together.
    always @(negedge CLK) begin
        if (HOP1_EN && !hop1_prev) hop1_rises++;
        hop1_prev = HOP1_EN;
        if (HOP0_EN && HOP1_EN) overlap_seen = 1'b1;
    end

    // Abort guard in case a stimulus sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] allOuts();
        return {8'd0, HOP0_EN, HOP1_EN, VEND, BUSY, OVF, EMPTY0, EMPTY1, FAULT, INV0, INV1};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic c0, input logic c1, input logic t);
        C0 = c0; C1 = c1; T = t;
        tick();
        C0 = 1'b0; C1 = 1'b0; T = 1'b0;
    endtask

    task automatic pulseSense(input logic s0, input logic s1);
        SENSE0 = s0; SENSE1 = s1;
        tick();
        SENSE0 = 1'b0; SENSE1 = 1'b0;
    endtask

    task automatic loadInv(input logic [7:0] a, input logic [7:0] b);
        LOAD = 1'b1; LOAD_CNT0 = a; LOAD_CNT1 = b;
        tick();
        LOAD = 1'b0;
    endtask

    initial begin
        int hi;
        int r0;
        int cyc;
        RESET = 1'b1; T = 0; C0 = 0; C1 = 0; LOAD = 0; SENSE0 = 0; SENSE1 = 0;
        CLR_FAULT = 0; LOAD_CNT0 = 0; LOAD_CNT1 = 0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        checkOutput("reset_outputs", allOuts(), 32'd0);

        // Basic payout with sense three cycles after enable rises.
        loadInv(8'd3, 8'd2);
        checkOutput("t1_inv0_load", INV0, 32'd3);
        checkOutput("t1_inv1_load", INV1, 32'd2);
        applyStimulus(1, 0, 0);
        checkOutput("t1_busy_queued", BUSY, 32'd1);
        checkOutput("t1_hop0_not_yet", HOP0_EN, 32'd0);
        tick();
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (HOP0_EN) hi++;
            tick();
        end
        if (HOP0_EN) hi++;
        pulseSense(1, 0);
        checkOutput("t1_hop0_high_cycles", hi, 32'd4);
        checkOutput("t1_hop0_drop", HOP0_EN, 32'd0);
        checkOutput("t1_inv0_dec", INV0, 32'd2);
        checkOutput("t1_busy_gap", BUSY, 32'd1);
        tick();
        checkOutput("t1_busy_idle", BUSY, 32'd0);

        // Simultaneous C0/C1: type 0 first, type 1 two edges after the sense.
        loadInv(8'd3, 8'd2);
        applyStimulus(1, 1, 0);
        tick();
        checkOutput("t2_hop0_first", HOP0_EN, 32'd1);
        checkOutput("t2_hop1_wait", HOP1_EN, 32'd0);
        pulseSense(1, 0);
        checkOutput("t2_hop0_drop", HOP0_EN, 32'd0);
        tick();
        checkOutput("t2_hop1_gap", HOP1_EN, 32'd0);
        tick();
        checkOutput("t2_hop1_rise", HOP1_EN, 32'd1);
        checkOutput("t2_hop0_low", HOP0_EN, 32'd0);
        pulseSense(0, 1);
        checkOutput("t2_hop1_drop", HOP1_EN, 32'd0);
        tick(); tick();
        checkOutput("t2_inv0", INV0, 32'd2);
        checkOutput("t2_inv1", INV1, 32'd1);
        checkOutput("t2_busy_idle", BUSY, 32'd0);

        // Overflow: six back-to-back C1 with no sense, recover each fault.
        loadInv(8'd3, 8'd10);
        r0 = hop1_rises;
        for (int i = 0; i < 6; i++) begin
            C1 = 1'b1;
            tick();
            if (i == 4) checkOutput("t3_ovf_before_drop", OVF, 32'd0);
        end
        C1 = 1'b0;
        checkOutput("t3_ovf_set", OVF, 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (!FAULT && cyc < 40) begin
                tick();
                cyc++;
            end
            checkOutput("t3_fault_reached", FAULT, 32'd1);
            CLR_FAULT = 1'b1;
            tick();
            CLR_FAULT = 1'b0;
        end
        tick(); tick();
        checkOutput("t3_payout_attempts", hop1_rises - r0, 32'd5);
        checkOutput("t3_busy_done", BUSY, 32'd0);
        checkOutput("t3_inv1_unchanged", INV1, 32'd10);

        // Timeout exactly 16 cycles after enable; queued C1 pays after clear.
        loadInv(8'd5, 8'd4);
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("t4_hop0_rise", HOP0_EN, 32'd1);
        for (int i = 1; i <= 15; i++) begin
            if (i == 1) C1 = 1'b1;
            if (i == 5) SENSE1 = 1'b1;
            tick();
            C1 = 1'b0;
            SENSE1 = 1'b0;
        end
        checkOutput("t4_no_fault_at_15", FAULT, 32'd0);
        checkOutput("t4_hop0_held", HOP0_EN, 32'd1);
        tick();
        checkOutput("t4_fault_at_16", FAULT, 32'd1);
        checkOutput("t4_hop0_off", HOP0_EN, 32'd0);
        checkOutput("t4_inv0_kept", INV0, 32'd5);
        checkOutput("t4_busy_fault", BUSY, 32'd1);
        CLR_FAULT = 1'b1;
        tick();
        CLR_FAULT = 1'b0;
        checkOutput("t4_fault_clear", FAULT, 32'd0);
        tick();
        checkOutput("t4_hop1_after_clear", HOP1_EN, 32'd1);
        pulseSense(0, 1);
        checkOutput("t4_inv1_dec", INV1, 32'd3);
        tick(); tick();
        checkOutput("t4_busy_idle", BUSY, 32'd0);

        // Empty inventory: request is discarded with a sticky flag.
        loadInv(8'd5, 8'd0);
        r0 = hop1_rises;
        applyStimulus(0, 1, 0);
        checkOutput("t5_empty1_not_yet", EMPTY1, 32'd0);
        tick();
        checkOutput("t5_empty1_set", EMPTY1, 32'd1);
        checkOutput("t5_empty0_clear", EMPTY0, 32'd0);
        checkOutput("t5_busy_idle", BUSY, 32'd0);
        tick(); tick();
        checkOutput("t5_no_hop1", hop1_rises - r0, 32'd0);
        checkOutput("t5_empty1_sticky", EMPTY1, 32'd1);

        // Vend retrigger two cycles after the first pulse stretches to six cycles.
        T = 1'b1;
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            T = (i == 1);
            if (VEND) hi++;
        end
        checkOutput("t6_vend_cycles", hi, 32'd6);
        checkOutput("t6_vend_low", VEND, 32'd0);

        // Asynchronous reset in the middle of a dispense with vend active.
        loadInv(8'd3, 8'd3);
        applyStimulus(1, 0, 0);
        tick();
        applyStimulus(0, 0, 1);
        checkOutput("t6_hop0_before_reset", HOP0_EN, 32'd1);
        checkOutput("t6_vend_before_reset", VEND, 32'd1);
        checkOutput("t6_ovf_sticky", OVF, 32'd1);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("t6_async_reset_outs", allOuts(), 32'd0);
        tick();
        RESET = 1'b0;
        tick();
        checkOutput("t6_after_reset_outs", allOuts(), 32'd0);

        checkOutput("no_hopper_overlap", overlap_seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
